// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data-memory port between the CPU MEM stage and a debug/loader requester.
// Define DMEM_ARB_PERF_EN to add the saturating o_stall_count performance counter.
module dmem_arbiter #(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 16,
    parameter int STARVE_LIMIT = 3,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_cpu_req,
    input  logic                  i_cpu_we,
    input  logic [ADDR_WIDTH-1:0] i_cpu_addr,
    input  logic [DATA_WIDTH-1:0] i_cpu_wdata,
    output logic [DATA_WIDTH-1:0] o_cpu_rdata,
    output logic                  o_cpu_stall,
    input  logic                  i_dbg_req,
    input  logic                  i_dbg_we,
    input  logic [ADDR_WIDTH-1:0] i_dbg_addr,
    input  logic [DATA_WIDTH-1:0] i_dbg_wdata,
    output logic [DATA_WIDTH-1:0] o_dbg_rdata,
    output logic                  o_dbg_ack,
    output logic                  o_mem_read,
    output logic                  o_mem_write,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
`ifdef DMEM_ARB_PERF_EN
    output logic [CNT_WIDTH-1:0]  o_stall_count,
`endif
    input  logic [DATA_WIDTH-1:0] i_mem_rdata
);
    typedef enum logic {IDLE, DBG_ACK} state_t;
    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    state_t     r_state, w_state_nxt;
    logic [7:0] r_starve_cnt, w_starve_nxt;
    logic       w_dbg_grant, w_cpu_grant;

    // Grants are gated by reset so nothing reaches memory while it is held.
    assign w_dbg_grant = i_rst_n & (r_state == IDLE) & i_dbg_req & (~i_cpu_req | (r_starve_cnt == LIMIT));
    assign w_cpu_grant = i_rst_n & i_cpu_req & ~w_dbg_grant;

    assign o_mem_read  = w_cpu_grant ? ~i_cpu_we : w_dbg_grant & ~i_dbg_we;
    assign o_mem_write = w_cpu_grant ? i_cpu_we : w_dbg_grant & i_dbg_we;
    assign o_mem_addr  = w_cpu_grant ? i_cpu_addr : w_dbg_grant ? i_dbg_addr : '0;
    assign o_mem_wdata = w_cpu_grant ? i_cpu_wdata : w_dbg_grant ? i_dbg_wdata : '0;
    assign o_cpu_rdata = i_mem_rdata;
    assign o_cpu_stall = i_rst_n & i_cpu_req & ~w_cpu_grant;

    always_comb begin
        w_state_nxt  = (r_state == IDLE && w_dbg_grant) ? DBG_ACK : IDLE;
        w_starve_nxt = w_dbg_grant ? 8'd0
                     : (r_state == IDLE && i_dbg_req && r_starve_cnt != LIMIT) ? r_starve_cnt + 8'd1
                     : r_starve_cnt;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_starve_cnt <= 8'd0;
            o_dbg_ack    <= 1'b0;
            o_dbg_rdata  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_starve_cnt <= w_starve_nxt;
            o_dbg_ack    <= w_dbg_grant;
            if (w_dbg_grant && !i_dbg_we)
                o_dbg_rdata <= i_mem_rdata;
        end
    end

`ifdef DMEM_ARB_PERF_EN
    logic [CNT_WIDTH-1:0] r_stall_count;
    assign o_stall_count = r_stall_count;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_stall_count <= '0;
        else if (o_cpu_stall && !(&r_stall_count))
            r_stall_count <= r_stall_count + 1'b1;
    end
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: table-driven, scoreboarded check of dmem_arbiter against a behavioural DMEM.
module tb_dmem_arbiter;
    localparam logic H = 1'b1, L = 1'b0;
    localparam logic [7:0]  Z8  = 8'h00;
    localparam logic [15:0] Z16 = 16'h0000;

    typedef struct {
        logic rn, cr, cw; logic [7:0] ca; logic [15:0] cd;
        logic dr, dw; logic [7:0] da; logic [15:0] dd;
        logic rd, wr; logic [7:0] ad; logic [15:0] wd;
        logic st, ak; logic [15:0] drd;
        logic ck; logic [15:0] crd;
    } vec_t;

    logic        clk = 1'b0, rst_n = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0, dbg_req = 1'b0, dbg_we = 1'b0;
    logic [7:0]  cpu_addr = 8'h00, dbg_addr = 8'h00;
    logic [15:0] cpu_wdata = 16'h0, dbg_wdata = 16'h0;
    logic [15:0] cpu_rdata, dbg_rdata, mem_wdata, mem_rdata;
    logic        cpu_stall, dbg_ack, mem_read, mem_write;
    logic [7:0]  mem_addr;
`ifdef DMEM_ARB_PERF_EN
    logic [15:0] stall_count;
    int          sc = 0;
`endif
    logic [15:0] mem [256];
    logic        booted = 1'b0;
    vec_t        tbl[$];
    vec_t        sb[$];
    int          n_vec = 0, n_bad = 0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
        .o_cpu_rdata(cpu_rdata), .o_cpu_stall(cpu_stall),
        .i_dbg_req(dbg_req), .i_dbg_we(dbg_we), .i_dbg_addr(dbg_addr), .i_dbg_wdata(dbg_wdata),
        .o_dbg_rdata(dbg_rdata), .o_dbg_ack(dbg_ack),
        .o_mem_read(mem_read), .o_mem_write(mem_write), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
`ifdef DMEM_ARB_PERF_EN
        .o_stall_count(stall_count),
`endif
        .i_mem_rdata(mem_rdata)
    );

    // DMEM: combinational read, write on the rising edge; preloaded on the first edge.
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (!booted) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'h0;
            mem[8'h05] <= 16'h1234;
            mem[8'h20] <= 16'h5555;
            booted <= 1'b1;
        end else if (mem_write)
            mem[mem_addr] <= mem_wdata;
    end

    function automatic vec_t mk(input logic rn, cr, cw, input logic [7:0] ca, input logic [15:0] cd,
                                input logic dr, dw, input logic [7:0] da, input logic [15:0] dd,
                                input logic rd, wr, input logic [7:0] ad, input logic [15:0] wd,
                                input logic st, ak, input logic [15:0] drd,
                                input logic ck, input logic [15:0] crd);
        vec_t v;
        v.rn = rn; v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
        v.dr = dr; v.dw = dw; v.da = da; v.dd = dd;
        v.rd = rd; v.wr = wr; v.ad = ad; v.wd = wd;
        v.st = st; v.ak = ak; v.drd = drd; v.ck = ck; v.crd = crd;
        return v;
    endfunction

    task automatic run(input vec_t v, input string nm);
        vec_t e;
        logic [43:0] act, exp;
        @(posedge clk);
        #1;
        rst_n = v.rn; cpu_req = v.cr; cpu_we = v.cw; cpu_addr = v.ca; cpu_wdata = v.cd;
        dbg_req = v.dr; dbg_we = v.dw; dbg_addr = v.da; dbg_wdata = v.dd;
        sb.push_back(v);
        @(negedge clk);
        e = sb.pop_front();
        act = {mem_read, mem_write, mem_addr, mem_wdata, cpu_stall, dbg_ack, dbg_rdata};
        exp = {e.rd, e.wr, e.ad, e.wd, e.st, e.ak, e.drd};
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: {rd,wr,addr,wdata,stall,ack,dbg_rdata} got %h want %h", nm, act, exp);
        end
        if (e.ck) begin
            n_vec++;
            if (cpu_rdata !== e.crd) begin
                n_bad++;
                $display("FAIL %s cpu_rdata: got %h want %h", nm, cpu_rdata, e.crd);
            end
        end
`ifdef DMEM_ARB_PERF_EN
        if (!e.rn) sc = 0;
        n_vec++;
        if (stall_count !== 16'(sc)) begin
            n_bad++;
            $display("FAIL %s stall_count: got %0d want %0d", nm, stall_count, sc);
        end
        if (e.rn && e.st) sc++;
`endif
    endtask

    initial begin
        //          rn cr cw ca     cd        dr dw da     dd         rd wr ad     wd         st ak drd        ck crd
        tbl.push_back(mk(L, H, H, 8'h10, 16'hBEEF, H, L, 8'h05, Z16,      L, L, Z8,    Z16,       L, L, Z16,       L, Z16));
        tbl.push_back(mk(L, L, L, Z8,    Z16,      L, L, Z8,    Z16,      L, L, Z8,    Z16,       L, L, Z16,       L, Z16));
        tbl.push_back(mk(H, H, H, 8'h10, 16'hBEEF, L, L, Z8,    Z16,      L, H, 8'h10, 16'hBEEF,  L, L, Z16,       L, Z16));
        tbl.push_back(mk(H, H, L, 8'h10, 16'h1111, L, L, Z8,    Z16,      H, L, 8'h10, 16'h1111,  L, L, Z16,       H, 16'hBEEF));
        tbl.push_back(mk(H, L, L, Z8,    Z16,      L, L, Z8,    Z16,      L, L, Z8,    Z16,       L, L, Z16,       L, Z16));
        tbl.push_back(mk(H, L, L, Z8,    Z16,      H, L, 8'h05, 16'h7777, H, L, 8'h05, 16'h7777,  L, L, Z16,       L, Z16));
        tbl.push_back(mk(H, L, L, Z8,    Z16,      H, L, 8'h05, 16'h7777, L, L, Z8,    Z16,       L, H, 16'h1234,  L, Z16));
        tbl.push_back(mk(H, L, L, Z8,    Z16,      L, L, Z8,    Z16,      L, L, Z8,    Z16,       L, L, 16'h1234,  L, Z16));
        // dbg_req held with no CPU traffic: grant, ack, grant, ack, ...
        for (int i = 0; i < 3; i++) begin
            tbl.push_back(mk(H, L, L, Z8, Z16, H, L, 8'h20, Z16, H, L, 8'h20, Z16, L, L, i == 0 ? 16'h1234 : 16'h5555, L, Z16));
            tbl.push_back(mk(H, L, L, Z8, Z16, H, L, 8'h20, Z16, L, L, Z8,    Z16, L, H, 16'h5555, L, Z16));
        end
        tbl.push_back(mk(H, L, L, Z8,    Z16,      L, L, Z8,    Z16,      L, L, Z8,    Z16,       L, L, 16'h5555,  L, Z16));
        tbl.push_back(mk(H, L, L, Z8,    Z16,      H, H, 8'h30, 16'hCAFE, L, H, 8'h30, 16'hCAFE,  L, L, 16'h5555,  L, Z16));
        tbl.push_back(mk(H, L, L, Z8,    Z16,      L, L, Z8,    Z16,      L, L, Z8,    Z16,       L, H, 16'h5555,  L, Z16));
        tbl.push_back(mk(H, H, L, 8'h30, Z16,      L, L, Z8,    Z16,      H, L, 8'h30, Z16,       L, L, 16'h5555,  H, 16'hCAFE));
        // contention: CPU wins three cycles, debug forced on the fourth
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(H, H, L, 8'h10, 16'h2222, H, L, 8'h05, 16'h3333, H, L, 8'h10, 16'h2222, L, L, 16'h5555, H, 16'hBEEF));
        tbl.push_back(mk(H, H, L, 8'h10, 16'h2222, H, L, 8'h05, 16'h3333, H, L, 8'h05, 16'h3333,  H, L, 16'h5555,  L, Z16));
        tbl.push_back(mk(H, H, L, 8'h10, 16'h2222, H, L, 8'h05, 16'h3333, H, L, 8'h10, 16'h2222,  L, H, 16'h1234,  H, 16'hBEEF));
        tbl.push_back(mk(H, H, L, 8'h10, 16'h2222, H, L, 8'h05, 16'h3333, H, L, 8'h10, 16'h2222,  L, L, 16'h1234,  H, 16'hBEEF));
        tbl.push_back(mk(H, H, L, 8'h10, 16'h2222, H, L, 8'h05, 16'h3333, H, L, 8'h10, 16'h2222,  L, L, 16'h1234,  H, 16'hBEEF));
        // starve count (2) holds while dbg_req is low, so the next contention forces debug after one cycle
        tbl.push_back(mk(H, L, L, Z8,    Z16,      L, L, Z8,    Z16,      L, L, Z8,    Z16,       L, L, 16'h1234,  L, Z16));
        tbl.push_back(mk(H, H, H, 8'h40, 16'hAAAA, H, H, 8'h41, 16'hBBBB, L, H, 8'h40, 16'hAAAA,  L, L, 16'h1234,  L, Z16));
        tbl.push_back(mk(H, H, H, 8'h40, 16'hAAAA, H, H, 8'h41, 16'hBBBB, L, H, 8'h41, 16'hBBBB,  H, L, 16'h1234,  L, Z16));
        tbl.push_back(mk(H, H, H, 8'h40, 16'hAAAA, H, H, 8'h41, 16'hBBBB, L, H, 8'h40, 16'hAAAA,  L, H, 16'h1234,  L, Z16));
        tbl.push_back(mk(H, H, L, 8'h41, Z16,      L, L, Z8,    Z16,      H, L, 8'h41, Z16,       L, L, 16'h1234,  H, 16'hBBBB));
        tbl.push_back(mk(H, L, L, Z8,    Z16,      L, L, Z8,    Z16,      L, L, Z8,    Z16,       L, L, 16'h1234,  L, Z16));

        #2 rst_n = 1'b0;
        foreach (tbl[i]) run(tbl[i], $sformatf("vec%0d", i));

        // reset lands in the DBG_ACK cycle: the pending ack is dropped
        run(mk(H, L, L, Z8,    Z16,      H, L, 8'h20, Z16, H, L, 8'h20, Z16, L, L, 16'h1234, L, Z16), "rack_grant");
        run(mk(L, H, H, 8'h10, 16'h9999, H, L, 8'h20, Z16, L, L, Z8,    Z16, L, L, Z16,      L, Z16), "rack_in_rst0");
        run(mk(L, H, H, 8'h10, 16'h9999, H, L, 8'h20, Z16, L, L, Z8,    Z16, L, L, Z16,      L, Z16), "rack_in_rst1");
        for (int i = 0; i < 3; i++)
            run(mk(H, H, L, 8'h10, Z16, H, L, 8'h20, Z16, H, L, 8'h10, Z16, L, L, Z16, H, 16'hBEEF), $sformatf("rack_cpu%0d", i));
        run(mk(H, H, L, 8'h10, Z16, H, L, 8'h20, Z16, H, L, 8'h20, Z16, H, L, Z16,      L, Z16), "rack_forced");
        run(mk(H, H, L, 8'h10, Z16, H, L, 8'h20, Z16, H, L, 8'h10, Z16, L, H, 16'h5555, H, 16'hBEEF), "rack_ack");
        run(mk(H, L, L, Z8,    Z16, L, L, Z8,    Z16, L, L, Z8,    Z16, L, L, 16'h5555, L, Z16), "rack_idle");

        // reset with a partially built starve count: count restarts from zero
        run(mk(H, H, L, 8'h10, Z16, H, L, 8'h05, Z16, H, L, 8'h10, Z16, L, L, 16'h5555, L, Z16), "rcnt_cpu0");
        run(mk(H, H, L, 8'h10, Z16, H, L, 8'h05, Z16, H, L, 8'h10, Z16, L, L, 16'h5555, L, Z16), "rcnt_cpu1");
        run(mk(L, H, L, 8'h10, Z16, H, L, 8'h05, Z16, L, L, Z8,    Z16, L, L, Z16,      L, Z16), "rcnt_rst");
        for (int i = 0; i < 3; i++)
            run(mk(H, H, L, 8'h10, Z16, H, L, 8'h05, Z16, H, L, 8'h10, Z16, L, L, Z16, L, Z16), $sformatf("rcnt_after%0d", i));
        run(mk(H, H, L, 8'h10, Z16, H, L, 8'h05, Z16, H, L, 8'h05, Z16, H, L, Z16,      L, Z16), "rcnt_forced");
        run(mk(H, H, L, 8'h10, Z16, H, L, 8'h05, Z16, H, L, 8'h10, Z16, L, H, 16'h1234, L, Z16), "rcnt_ack");
        run(mk(H, L, L, Z8,    Z16, L, L, Z8,    Z16, L, L, Z8,    Z16, L, L, 16'h1234, L, Z16), "rcnt_idle");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
